// File: rtl/mealy_1101.sv
// Mealy detector for the serial pattern 1-1-0-1 (oldest bit first, overlap allowed).
// z is purely combinational from the current state and x, and is gated low while reset is asserted.
module mealy_1101 (
   input  logic clk,
   input  logic reset,
   input  logic x,
   output logic z
);

   typedef enum logic [1:0] {
      S0   = 2'b00,
      S1   = 2'b01,
      S11  = 2'b10,
      S110 = 2'b11
   } state_t;

   state_t r_state;
   state_t w_state_next;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S0;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = S0;
      z            = 1'b0;
      case (r_state)
         S0:   w_state_next = x ? S1  : S0;
         S1:   w_state_next = x ? S11 : S0;
         // Extra 1s keep the "11" prefix alive.
         S11:  w_state_next = x ? S11 : S110;
         S110: begin
            // The completing 1 also seeds the next match.
            w_state_next = x ? S1 : S0;
            z            = x & reset;
         end
         default: begin
            w_state_next = S0;
            z            = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_mealy_1101.sv
// Directed-vector bench for mealy_1101: each bit is driven at the falling edge and
// z is checked mid-cycle; the state register is inspected shortly after rising edges.
module tb_mealy_1101;

   logic clk;
   logic reset;
   logic x;
   logic z;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [1:0] ST_S0   = 2'b00;
   localparam logic [1:0] ST_S1   = 2'b01;
   localparam logic [1:0] ST_S11  = 2'b10;
   localparam logic [1:0] ST_S110 = 2'b11;

   mealy_1101 dut (
      .clk   (clk),
      .reset (reset),
      .x     (x),
      .z     (z)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] cur_state();
      logic [1:0] s;
      s = dut.r_state;
      return s;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      x     = 1'b0;
      reset = 1'b0;
      #2;
      reset = 1'b1;
   endtask

   // bits/zexp are written left-to-right, first bit at index 0.
   task automatic run_seq(input string name, input logic [0:15] bits,
                          input logic [0:15] zexp, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         x = bits[i];
         #1;
         check($sformatf("%s_b%0d", name, i + 1), {7'd0, z}, {7'd0, zexp[i]});
         $display("%s bit%0d x=%0b z=%0b expz=%0b", name, i + 1, x, z, zexp[i]);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      x     = 1'b1;
      #1;
      reset = 1'b0;
      #2;
      check("rst_z", {7'd0, z}, 8'd0);
      check("rst_state", {6'd0, cur_state()}, {6'd0, ST_S0});
      #8;
      reset = 1'b1;
      x     = 1'b0;

      // Basic match
      run_seq("basic", 16'b1101_0000_0000_0000, 16'b0001_0000_0000_0000, 4);
      check("basic_state", {6'd0, cur_state()}, {6'd0, ST_S1});

      // Back-to-back matches, with state check after bit 5
      do_reset();
      run_seq("b2b_a", 16'b1101_1000_0000_0000, 16'b0001_0000_0000_0000, 5);
      check("b2b_state_b5", {6'd0, cur_state()}, {6'd0, ST_S11});
      run_seq("b2b_b", 16'b1010_0000_0000_0000, 16'b0010_0000_0000_0000, 3);

      // Overlapped match
      do_reset();
      run_seq("ovl", 16'b1101_1010_0000_0000, 16'b0001_0010_0000_0000, 7);

      // Near misses
      do_reset();
      run_seq("near_a", 16'b1011_0000_0000_0000, 16'b0000_0000_0000_0000, 4);
      check("near_state_s11", {6'd0, cur_state()}, {6'd0, ST_S11});
      run_seq("near_b", 16'b0000_0000_0000_0000, 16'b0000_0000_0000_0000, 2);
      check("near_state_s0", {6'd0, cur_state()}, {6'd0, ST_S0});
      run_seq("near_c", 16'b1000_0000_0000_0000, 16'b0000_0000_0000_0000, 1);

      // Reset pulse mid-pattern
      do_reset();
      run_seq("rmid", 16'b1100_0000_0000_0000, 16'b0000_0000_0000_0000, 3);
      check("rmid_s110", {6'd0, cur_state()}, {6'd0, ST_S110});
      @(negedge clk);
      x = 1'b1;
      #1;
      check("rmid_pre_z", {7'd0, z}, 8'd1);
      reset = 1'b0;
      #1;
      check("rmid_rst_z", {7'd0, z}, 8'd0);
      check("rmid_rst_state", {6'd0, cur_state()}, {6'd0, ST_S0});
      reset = 1'b1;
      #1;
      check("rmid_post_z", {7'd0, z}, 8'd0);
      @(posedge clk);
      #1;
      check("rmid_state_s1", {6'd0, cur_state()}, {6'd0, ST_S1});
      check("rmid_after_z", {7'd0, z}, 8'd0);
      $display("rmid reset pulse then x=1 state=%0d z=%0b", cur_state(), z);

      // Mealy timing: x toggles inside one period while in S110
      do_reset();
      run_seq("mt", 16'b1100_0000_0000_0000, 16'b0000_0000_0000_0000, 3);
      @(negedge clk);
      x = 1'b0;
      #1;
      check("mt_z_x0", {7'd0, z}, 8'd0);
      x = 1'b1;
      #1;
      check("mt_z_x1", {7'd0, z}, 8'd1);
      x = 1'b0;
      #1;
      check("mt_z_x0b", {7'd0, z}, 8'd0);
      @(posedge clk);
      #1;
      check("mt_state_s0", {6'd0, cur_state()}, {6'd0, ST_S0});
      $display("mt toggle done state=%0d", cur_state());

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mealy_1101.md
MEALY_1101 -- requirements
Module: mealy_1101

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 x  input  1  serial bit stream; sampled on each rising clk edge.
REQ-005 z  output  1  Mealy detect flag; high while the current x completes 1101.

Function
REQ-006 The block SHALL be a Mealy FSM detecting serial pattern 1-1-0-1, oldest bit first, with overlap allowed.
REQ-007 The block SHALL implement exactly four states, 2-bit encoded:
- S0 = no useful prefix
- S1 = seen "1"
- S11 = seen "11"
- S110 = seen "110"
REQ-008 The state SHALL update only on the rising clk edge while reset is high.
REQ-009 Transitions from S0 SHALL be: x=1 -> S1; x=0 -> S0.
REQ-010 Transitions from S1 SHALL be: x=1 -> S11; x=0 -> S0.
REQ-011 Transitions from S11 SHALL be: x=1 -> S11 (extra 1s keep the "11" prefix); x=0 -> S110.
REQ-012 Transitions from S110 SHALL be: x=1 -> S1 (the final 1 seeds the next match); x=0 -> S0.
REQ-013 z SHALL be combinational: z = 1 iff state == S110 and x == 1 and reset == 1; otherwise z = 0.
REQ-014 z SHALL respond to x changes within the same cycle, with zero-cycle latency and no registering.
REQ-015 Each complete pattern SHALL produce exactly one z-high cycle, aligned with the cycle whose sampled x is the final 1.
REQ-016 An overlapped match SHALL be detected: in 1101101 the second match completes at bit 7, and z SHALL be high at bits 4 and 7.
REQ-017 Unused state codes (if any) SHALL transition to S0 with z = 0.

Reset
REQ-018 reset = 0 SHALL force state to S0 immediately, without waiting for a clock edge.
REQ-019 While reset = 0, z SHALL be 0 regardless of x.
REQ-020 Reset SHALL discard any partial match.
REQ-021 After reset deasserts, the first rising edge SHALL evaluate from S0.
REQ-022 Reset asserted mid-pattern (e.g. after "110") SHALL leave no prefix, so a following lone 1 SHALL NOT assert z.

Verification
REQ-023 The bench SHALL cover a basic match: reset low 10 ns, then x = 1,1,0,1 on successive cycles (10 ns clock) -> z high only during the 4th bit cycle.
REQ-024 The bench SHALL cover back-to-back matches: x = 1,1,0,1,1,1,0,1 -> z high at bits 4 and 8 only; state after bit 5 is S11.
REQ-025 The bench SHALL cover an overlapped match: x = 1,1,0,1,1,0,1 -> z high at bits 4 and 7.
REQ-026 The bench SHALL cover near misses: x = 1,0,1,1,0,0,1 -> z never high; state returns to S0 after the final 0,0.
REQ-027 The bench SHALL cover reset mid-operation: x = 1,1,0, then pulse reset low between edges, then x = 1 -> z stays 0 and state is S1 after that edge.
REQ-028 The bench SHALL cover Mealy timing: in S110, toggle x 0 -> 1 -> 0 within one clock period -> z follows x combinationally.
